// File: rtl/pc_redirect_unit.sv
// Fetch-side program counter owner: takes the EX-stage redirect decision, computes
// branch/JAL/JALR targets, sequences the post-jump fetch bubble, halt and trap entry.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       branch_sel,
    input  logic [31:0]      pc_ex,
    input  logic [31:0]      imm_ex,
    input  logic [31:0]      rs1_ex,
    input  logic             stall,
    input  logic             halt,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             fetch_valid,
    output logic             misaligned,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               misaligned_q, misaligned_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               redirect;
    logic [31:0]        target;

    // A halted core ignores EX decisions; code 10 is a reserved alias of sequential.
    always_comb begin
        redirect = (branch_sel == 2'b01 || branch_sel == 2'b11) && (state_q != HALTED);
        if (branch_sel[1]) begin
            target = (rs1_ex + imm_ex) & ~32'h1;
        end else begin
            target = pc_ex + imm_ex;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        halted_d     = halted_q;
        count_d      = count_q;

        if (redirect) begin
            if (target[1:0] == 2'b00) begin
                pc_d = target;
            end else begin
                pc_d         = TRAP_VECTOR;
                misaligned_d = 1'b1;
            end
            state_d = FLUSH;
            if (count_q != {CNT_W{1'b1}}) begin
                count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (halt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
        end else if (!stall) begin
            pc_d    = pc_q + 32'd4;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FLUSH;
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
            halted_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            halted_q     <= halted_d;
            count_q      <= count_d;
        end
    end

    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign flush_if_id    = redirect;
    assign flush_id_ex    = redirect;
    assign fetch_valid    = (state_q == RUN);
    assign misaligned     = misaligned_q;
    assign halted         = halted_q;
    assign redirect_count = count_q;

endmodule
